// File: rtl/sum_accumulator.sv
// Streaming frame accumulator: totals unsigned 32-bit beats into an ACC_WIDTH sum with beat count.
// Define SUM_ACCUMULATOR_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module sum_accumulator #(
  parameter int unsigned ACC_WIDTH = 40,
  parameter int unsigned COUNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [COUNT_W-1:0]   out_count,
  output logic                 out_ovf
);

  localparam int unsigned SumW = ACC_WIDTH + 1;

  typedef enum logic [0:0] {StAccum, StDone} state_e;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
  logic [COUNT_W-1:0]   out_count_q, out_count_d;
  logic                 out_ovf_q, out_ovf_d;

  logic                 accept;
  logic [SumW-1:0]      sum_ext;
  logic                 carry;
  logic [ACC_WIDTH-1:0] acc_new;
  logic [COUNT_W-1:0]   cnt_new;
  logic                 ovf_new;

  assign in_ready = rst_n & ((state_q == StAccum) | out_ready);
  assign accept   = in_valid & in_ready;

  // acc/cnt/ovf are cleared when a frame closes, so this update also covers the
  // first beat of a frame accepted in the DONE state.
  assign sum_ext = SumW'(acc_q) + SumW'(in_data);
  assign carry   = sum_ext[ACC_WIDTH];
`ifdef SUM_ACCUMULATOR_SAT_EN
  assign acc_new = carry ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
`else
  assign acc_new = sum_ext[ACC_WIDTH-1:0];
`endif
  assign cnt_new = (cnt_q == {COUNT_W{1'b1}}) ? cnt_q : cnt_q + COUNT_W'(1);
  assign ovf_new = ovf_q | carry;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    unique case (state_q)
      StAccum: ;
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase

    if (accept) begin
      if (in_last) begin
        out_sum_d   = acc_new;
        out_count_d = cnt_new;
        out_ovf_d   = ovf_new;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        state_d     = StDone;
      end else begin
        acc_d = acc_new;
        cnt_d = cnt_new;
        ovf_d = ovf_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAccum;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: directed frames then randomized traffic vs a frame model.
module tb_sum_accumulator;

  localparam int unsigned AW = 33;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_sum;
  logic [CW-1:0] out_count;
  logic          out_ovf;

  sum_accumulator #(.ACC_WIDTH(AW), .COUNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned sum;
    int unsigned     cnt;
    logic            ovf;
  } exp_t;

  exp_t            exp_q[$];
  int              n_vec = 0;
  int              n_err = 0;
  logic            pending = 1'b0;
  longint unsigned m_total = 0;
  int unsigned     m_beats = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame result from the true total: overflow iff the exact sum reaches 2^AW.
  function automatic exp_t frame_result(input longint unsigned total, input int unsigned beats);
    exp_t            e;
    longint unsigned lim;
    lim   = longint'(1) << AW;
    e.ovf = (total >= lim);
`ifdef SUM_ACCUMULATOR_SAT_EN
    e.sum = e.ovf ? lim - 1 : total;
`else
    e.sum = total % lim;
`endif
    e.cnt = (beats > (2 ** CW) - 1) ? (2 ** CW) - 1 : beats;
    return e;
  endfunction

  task automatic cycle(input logic v, input logic [31:0] d, input logic l, input logic r);
    logic acc;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    #4;
    check("out_valid", longint'(out_valid), longint'(pending));
    check("in_ready", longint'(in_ready), longint'(!pending || r));
    acc = v && (!pending || r);
    if (pending && r) pending = 1'b0;
    if (acc) begin
      m_total += longint'(d);
      m_beats++;
      if (l) begin
        exp_q.push_back(frame_result(m_total, m_beats));
        m_total = 0;
        m_beats = 0;
        pending = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #4;
    check("rst out_valid", longint'(out_valid), 0);
    check("rst out_sum", longint'(out_sum), 0);
    check("rst out_count", longint'(out_count), 0);
    check("rst out_ovf", longint'(out_ovf), 0);
    check("rst in_ready", longint'(in_ready), 0);
    exp_q.delete();
    pending = 1'b0;
    m_total = 0;
    m_beats = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: held result must match the queue head; pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected result", longint'(out_valid), 0);
        end else begin
          check("out_sum", longint'(out_sum), exp_q[0].sum);
          check("out_count", longint'(out_count), longint'(exp_q[0].cnt));
          check("out_ovf", longint'(out_ovf), longint'(exp_q[0].ovf));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    do_reset();

    // Basic frame
    cycle(1, 1, 0, 1);
    cycle(1, 2, 0, 1);
    cycle(1, 3, 1, 1);
    cycle(0, 0, 0, 1);

    // Back-pressure, then ready together with a single-beat frame
    cycle(1, 10, 0, 1);
    cycle(1, 20, 1, 1);
    for (int i = 0; i < 5; i++) cycle(1, 99, 0, 0);
    cycle(1, 7, 1, 1);
    cycle(0, 0, 0, 1);

    // Overflow
    cycle(1, 32'hFFFF_FFFF, 0, 1);
    cycle(1, 32'hFFFF_FFFF, 0, 1);
    cycle(1, 32'hFFFF_FFFF, 1, 1);
    cycle(0, 0, 0, 1);

    // Count saturation
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 1);
    cycle(1, 1, 1, 1);
    cycle(0, 0, 0, 1);

    // Single zero beat
    cycle(1, 0, 1, 1);
    cycle(0, 0, 0, 1);

    // Reset mid-frame
    cycle(1, 5, 0, 1);
    cycle(1, 6, 0, 1);
    do_reset();
    cycle(1, 4, 1, 1);
    cycle(0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF :
          ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom;
      cycle(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) < 7));
      if (i == 1500) do_reset();
    end

    // Drain
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
    check("results left in queue", longint'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Streaming accumulator that sits directly downstream of the 32-bit ripple-carry adder and consumes its sum output. It totals a frame of unsigned 32-bit sums into a wider accumulator and counts the beats in the frame. It presents the frame total, beat count and overflow flag through a valid/ready output holding register. Input and output both use valid/ready handshakes, so the block can be placed between the adder and any back-pressuring consumer.

## Interface
- `ACC_WIDTH`, default 40: accumulator and result width in bits; must be >= 32.
- `COUNT_W`, default 8: beat-counter width in bits; must be >= 1.

- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `in_data`/`in_last` are valid.
- `in_ready` output 1: block can accept a beat this cycle.
- `in_data` input 32: unsigned sum from the adder; zero-extended to `ACC_WIDTH`.
- `in_last` input 1: this beat closes the frame.
- `out_valid` output 1: frame result is held.
- `out_ready` input 1: consumer takes the result.
- `out_sum` output `ACC_WIDTH`: frame total.
- `out_count` output `COUNT_W`: beats in the frame, saturating.
- `out_ovf` output 1: accumulator overflowed during the frame.

## Operation
- Two states:
  - ACCUM: collecting a frame.
  - DONE: result held.
- Beat accepted when `in_valid & in_ready`.
- `in_ready` by state:
  - ACCUM: 1.
  - DONE: equals `out_ready`.
  - While `rst_n` is low: 0.
- ACCUM, beat accepted with `in_last=0`:
  - acc <= acc + in_data.
  - cnt <= cnt + 1, saturating at all-ones.
  - ovf <= ovf | carry-out of bit `ACC_WIDTH-1`.
- ACCUM, beat accepted with `in_last=1`:
  - `out_sum`/`out_count`/`out_ovf` <= the updated acc/cnt/ovf values, including this beat.
  - `out_valid` <= 1.
  - acc, cnt, ovf <= 0.
  - Go to DONE.
- DONE:
  - Outputs held stable while `out_valid & ~out_ready`.
  - On `out_ready`: `out_valid` <= 0 and go to ACCUM.
  - If a beat is accepted in that same cycle, it is the first beat of the next frame: acc <= in_data, cnt <= 1.
  - If that simultaneous beat also has `in_last=1`, the next result loads immediately: `out_valid` stays 1 and the state stays DONE.
- Empty frames do not exist; every frame has at least one beat.
- ACCUM with no beat: all state unchanged.
- `out_sum`/`out_count`/`out_ovf` keep their last value after the handshake; they are don't-care while `out_valid=0`.
- `in_data` is unsigned. No sign extension.

## Timing
- Reset values:
  - `out_valid`=0, `out_sum`=0, `out_count`=0, `out_ovf`=0.
  - acc=0, cnt=0, state=ACCUM.
- `in_ready` is 1 from the first edge after `rst_n` deasserts.
- Latency: `out_valid` rises on the edge that accepts the `in_last` beat, i.e. the result is visible the cycle after that beat.
- Throughput:
  - One beat per cycle within a frame.
  - Zero bubbles between frames while `out_ready` is held high.
- `in_ready` is combinational from state, `out_ready` and `rst_n`; no other combinational input-to-output paths.
- Reset mid-frame: the partial frame is discarded and a held result is dropped. No output pulse.

## Configuration
- Macro `SUM_ACCUMULATOR_SAT_EN`.
- Defined: on overflow, acc clamps to all-ones (2^`ACC_WIDTH`-1) and stays clamped for the rest of the frame; `out_ovf`=1.
- Undefined: acc wraps modulo 2^`ACC_WIDTH`; `out_ovf`=1 is still reported (sticky per frame).
- Beat counter saturates in both builds.

## Test plan
- Basic frame, `out_ready`=1: beats 1, 2, 3 (`in_last` on 3).
  - Next cycle: `out_valid`=1, `out_sum`=6, `out_count`=3, `out_ovf`=0.
- Back-pressure: after a frame of 10, 20 (sum 30), hold `out_ready`=0 for 5 cycles.
  - Outputs stay at sum 30, count 2; `in_ready`=0.
  - Raise `out_ready` together with beat 7, `in_last=1`: next cycle `out_valid`=1, `out_sum`=7, `out_count`=1.
- Overflow, `ACC_WIDTH`=33: three beats of 0xFFFFFFFF.
  - Without the macro: `out_sum`=0x0FFFFFFFD, `out_ovf`=1.
  - With `SUM_ACCUMULATOR_SAT_EN`: `out_sum`=0x1FFFFFFFF, `out_ovf`=1.
- Count saturation, `COUNT_W`=2: five beats of 1.
  - `out_count`=3, `out_sum`=5.
- Single-beat frame: `in_data`=0, `in_last`=1.
  - `out_sum`=0, `out_count`=1, `out_ovf`=0.
- Reset mid-frame: after beats 5, 6, pulse `rst_n` low for 1 cycle.
  - All outputs 0 and `in_ready`=0 during reset.
  - Then frame 4 (`in_last`) gives `out_sum`=4, `out_count`=1.
